fp_to_linear: RTL

- Sequential decoder for the 8-bit floating-point format produced by the linear-to-FP converter. Input fields are sign S, 3-bit exponent E and 4-bit significand F.
- Reconstructs the 12-bit two's-complement value D = (S ? -1 : +1) * F * 2^E.
- The significand is shifted one position per clock, so one conversion is in flight at a time.
- Sits downstream of the FP converter, for loopback checking and for consumers that need linear samples.
- Valid/ready handshake on both input and output.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_to_linear_if.sv | 27 ++
 rtl/fp_to_linear.sv | 86 ++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP <-> linear converter pair: field widths,
// FSM state encoding and the normalisation test on an FP code.
package fp_pkg;

  localparam int DW = 12;  // linear sample width
  localparam int EW = 3;   // exponent width
  localparam int FW = 4;   // significand width

  // State encoding, kept as plain constants so both converters agree on it
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SIGN  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // A code is non-normalized when it has a nonzero exponent but the
  // significand MSB is clear (the encoder would never emit it).
  function automatic logic is_nonnorm(input logic [EW-1:0] e, input logic [FW-1:0] f);
    return (e != {EW{1'b0}}) && (f[FW-1] == 1'b0);
  endfunction

endpackage

// File: rtl/fp_to_linear_if.sv
// Input (S/E/F) and output (D/nonnorm) handshake bundle of the FP decoder.
interface fp_to_linear_if;
  import fp_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic          S;
  logic [EW-1:0] E;
  logic [FW-1:0] F;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] D;
  logic          nonnorm;

  // Side that supplies FP codes and consumes linear results
  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, out_valid, D, nonnorm
  );

  // The decoder itself
  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, out_valid, D, nonnorm
  );

endinterface

// File: rtl/fp_to_linear.sv
// Sequential FP -> linear decoder. The zero-extended significand is shifted
// left once per clock for E cycles, then conditionally negated and held
// in DONE until the consumer takes it. One conversion in flight at a time.
module fp_to_linear
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fp_to_linear_if.slave   bus
);

  logic [1:0]    state_r;
  logic [DW-1:0] mag_r;
  logic [EW-1:0] cnt_r;
  logic          sign_r;
  logic          nn_flag_r;
  logic [DW-1:0] d_r;
  logic          nonnorm_r;
  logic          out_valid_r;
  logic          in_ready_r;

  // Control FSM, shift/count datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      mag_r       <= {DW{1'b0}};
      cnt_r       <= {EW{1'b0}};
      sign_r      <= 1'b0;
      nn_flag_r   <= 1'b0;
      d_r         <= {DW{1'b0}};
      nonnorm_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            mag_r      <= {{(DW-FW){1'b0}}, bus.F};
            cnt_r      <= bus.E;
            sign_r     <= bus.S;
            nn_flag_r  <= is_nonnorm(bus.E, bus.F);
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_r != {EW{1'b0}}) begin
            mag_r <= {mag_r[DW-2:0], 1'b0};
            cnt_r <= cnt_r - EW'(1);
          end else begin
            state_r <= SIGN;
          end
        end
        SIGN: begin
          // Negating zero yields zero in DW bits, so -0 never shows as 12'h800
          d_r         <= sign_r ? (~mag_r + DW'(1)) : mag_r;
          nonnorm_r   <= nn_flag_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.D         = d_r;
  assign bus.nonnorm   = nonnorm_r;

endmodule
